// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and the decoded control word shared by the decode stage and its
// immediate generator.
package rv_isa_pkg;

   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;

   localparam logic [1:0] RdSelMem = 2'b00;
   localparam logic [1:0] RdSelPc4 = 2'b01;
   localparam logic [1:0] RdSelAlu = 2'b10;
   localparam logic [1:0] RdSelImm = 2'b11;

   localparam logic [2:0] F3Add = 3'b000;
   localparam logic [2:0] F3Sll = 3'b001;
   localparam logic [2:0] F3Srl = 3'b101;

   localparam logic [6:0] F7Base = 7'b0000000;
   localparam logic [6:0] F7Alt  = 7'b0100000;

   typedef enum logic [2:0] {
      ImmNone,
      ImmI,
      ImmShamt,
      ImmS,
      ImmB,
      ImmU,
      ImmJ
   } imm_fmt_e;

   typedef struct packed {
      logic [4:0] rsa;
      logic [4:0] rsb;
      logic [4:0] rd;
      logic [2:0] func3;
      logic       sub_sra;
      logic       alu_sel_a;
      logic       alu_sel_b;
      logic [1:0] rd_sel;
      logic [2:0] sx_size;
      logic       pc_next_sel;
      logic       branch;
      logic       rd_we;
      logic       mem_we;
      logic       mem_re;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: picks the RV32I immediate layout for the decoded format and
// sign-extends it to XLEN.
module rv_imm_gen
   import rv_isa_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     insn,
   input  imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (fmt)
         ImmI:     imm32 = {{20{insn[31]}}, insn[31:20]};
         // Shifts carry only the shift amount; the func7 bits above it are not part of the value.
         ImmShamt: imm32 = {27'd0, insn[24:20]};
         ImmS:     imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         ImmB:     imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         ImmU:     imm32 = {insn[31:12], 12'd0};
         ImmJ:     imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default:  imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered, handshaked RV32I decode stage with an optional two-entry skid buffer between
// fetch and execute.
module rv_decode_stage
   import rv_isa_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter bit          SKID_EN = 1'b1,
   parameter bit          STRICT  = 1'b1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     INSN,
   input  logic [XLEN-1:0] pc_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [4:0]      rsa,
   output logic [4:0]      rsb,
   output logic [4:0]      rd,
   output logic [2:0]      func3,
   output logic            sub_sra,
   output logic            alu_sel_a,
   output logic            alu_sel_b,
   output logic [1:0]      rd_sel,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      sx_size,
   output logic            pc_next_sel,
   output logic            branch,
   output logic            rd_we,
   output logic            mem_we,
   output logic            mem_re,
   output logic            illegal
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   ctrl_t           ctrl;
   imm_fmt_e        fmt;
   logic            known;
   logic            reserved;
   logic [XLEN-1:0] imm_dec;

   assign opcode = INSN[6:0];
   assign f3     = INSN[14:12];
   assign f7     = INSN[31:25];

   always_comb begin
      ctrl        = '0;
      ctrl.rsa    = INSN[19:15];
      ctrl.rsb    = INSN[24:20];
      ctrl.rd     = INSN[11:7];
      ctrl.func3  = f3;
      ctrl.rd_sel = RdSelAlu;
      fmt         = ImmNone;
      known       = 1'b1;
      reserved    = 1'b0;
      case (opcode)
         OpcOp: begin
            ctrl.rd_we   = 1'b1;
            ctrl.sub_sra = INSN[30] | (f3[2:1] == 2'b01);
            reserved     = !((f7 == F7Base) || ((f7 == F7Alt) && ((f3 == F3Add) || (f3 == F3Srl))));
         end
         OpcOpImm: begin
            fmt            = ((f3 == F3Sll) || (f3 == F3Srl)) ? ImmShamt : ImmI;
            ctrl.rsb       = '0;
            ctrl.alu_sel_b = 1'b1;
            ctrl.rd_we     = 1'b1;
            ctrl.sub_sra   = ((f3 == F3Srl) && INSN[30]) || (f3[2:1] == 2'b01);
            reserved       = ((f3 == F3Sll) && (f7 != F7Base)) ||
                             ((f3 == F3Srl) && (f7 != F7Base) && (f7 != F7Alt));
         end
         OpcLoad: begin
            fmt            = ImmI;
            ctrl.rsb       = '0;
            ctrl.func3     = F3Add;
            ctrl.alu_sel_b = 1'b1;
            ctrl.rd_sel    = RdSelMem;
            ctrl.sx_size   = f3;
            ctrl.rd_we     = 1'b1;
            ctrl.mem_re    = 1'b1;
            reserved       = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OpcStore: begin
            fmt            = ImmS;
            ctrl.func3     = F3Add;
            ctrl.alu_sel_b = 1'b1;
            ctrl.sx_size   = f3;
            ctrl.mem_we    = 1'b1;
            reserved       = (f3 >= 3'b011);
         end
         OpcBranch: begin
            fmt          = ImmB;
            ctrl.sub_sra = 1'b1;
            ctrl.branch  = 1'b1;
            reserved     = (f3[2:1] == 2'b01);
         end
         OpcJal: begin
            fmt              = ImmJ;
            ctrl.rsa         = '0;
            ctrl.rsb         = '0;
            ctrl.func3       = F3Add;
            ctrl.alu_sel_a   = 1'b1;
            ctrl.alu_sel_b   = 1'b1;
            ctrl.rd_sel      = RdSelPc4;
            ctrl.pc_next_sel = 1'b1;
            ctrl.rd_we       = 1'b1;
         end
         OpcJalr: begin
            fmt              = ImmI;
            ctrl.rsb         = '0;
            ctrl.func3       = F3Add;
            ctrl.alu_sel_b   = 1'b1;
            ctrl.rd_sel      = RdSelPc4;
            ctrl.pc_next_sel = 1'b1;
            ctrl.rd_we       = 1'b1;
            reserved         = (f3 != F3Add);
         end
         OpcLui: begin
            fmt            = ImmU;
            ctrl.rsa       = '0;
            ctrl.rsb       = '0;
            ctrl.alu_sel_b = 1'b1;
            ctrl.rd_sel    = RdSelImm;
            ctrl.rd_we     = 1'b1;
         end
         OpcAuipc: begin
            fmt            = ImmU;
            ctrl.rsa       = '0;
            ctrl.rsb       = '0;
            ctrl.func3     = F3Add;
            ctrl.alu_sel_a = 1'b1;
            ctrl.alu_sel_b = 1'b1;
            ctrl.rd_we     = 1'b1;
         end
         default: known = 1'b0;
      endcase
      ctrl.illegal = !known || (STRICT && reserved);
      // An illegal instruction still flows downstream, but must have no side effects.
      if (ctrl.illegal || (ctrl.rd == 5'd0)) ctrl.rd_we = 1'b0;
      if (ctrl.illegal) begin
         ctrl.mem_we      = 1'b0;
         ctrl.mem_re      = 1'b0;
         ctrl.pc_next_sel = 1'b0;
         ctrl.branch      = 1'b0;
      end
   end

   rv_imm_gen #(
      .XLEN(XLEN)
   ) u_imm_gen (
      .insn(INSN),
      .fmt (fmt),
      .imm (imm_dec)
   );

   ctrl_t           out_ctrl_q, out_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
   logic [XLEN-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
   logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic            rdy_q;
   logic            accept;
   logic            out_free;

   assign out_free = ~out_valid_q | out_ready;
   // rdy_q holds off acceptance until the first edge after reset release.
   assign in_ready = rdy_q & (SKID_EN ? ~skid_valid_q : out_free);
   assign accept   = in_valid & in_ready & ~flush;

   always_comb begin
      out_ctrl_d   = out_ctrl_q;
      out_pc_d     = out_pc_q;
      out_imm_d    = out_imm_q;
      out_valid_d  = out_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_pc_d    = skid_pc_q;
      skid_imm_d   = skid_imm_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            // in_ready is low while the skid is full, so nothing new arrives this cycle.
            out_ctrl_d   = skid_ctrl_q;
            out_pc_d     = skid_pc_q;
            out_imm_d    = skid_imm_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) begin
               out_ctrl_d = ctrl;
               out_pc_d   = pc_in;
               out_imm_d  = imm_dec;
            end
         end
      end else if (accept) begin
         skid_ctrl_d  = ctrl;
         skid_pc_d    = pc_in;
         skid_imm_d   = imm_dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_ctrl_q   <= '0;
         out_pc_q     <= '0;
         out_imm_q    <= '0;
         out_valid_q  <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_pc_q    <= '0;
         skid_imm_q   <= '0;
         skid_valid_q <= 1'b0;
         rdy_q        <= 1'b0;
      end else begin
         out_ctrl_q   <= out_ctrl_d;
         out_pc_q     <= out_pc_d;
         out_imm_q    <= out_imm_d;
         out_valid_q  <= out_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_pc_q    <= skid_pc_d;
         skid_imm_q   <= skid_imm_d;
         skid_valid_q <= skid_valid_d;
         rdy_q        <= 1'b1;
      end
   end

   assign out_valid   = out_valid_q;
   assign pc_out      = out_pc_q;
   assign imm         = out_imm_q;
   assign rsa         = out_ctrl_q.rsa;
   assign rsb         = out_ctrl_q.rsb;
   assign rd          = out_ctrl_q.rd;
   assign func3       = out_ctrl_q.func3;
   assign sub_sra     = out_ctrl_q.sub_sra;
   assign alu_sel_a   = out_ctrl_q.alu_sel_a;
   assign alu_sel_b   = out_ctrl_q.alu_sel_b;
   assign rd_sel      = out_ctrl_q.rd_sel;
   assign sx_size     = out_ctrl_q.sx_size;
   assign pc_next_sel = out_ctrl_q.pc_next_sel;
   assign branch      = out_ctrl_q.branch;
   assign rd_we       = out_ctrl_q.rd_we;
   assign mem_we      = out_ctrl_q.mem_we;
   assign mem_re      = out_ctrl_q.mem_re;
   assign illegal     = out_ctrl_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a decode vector table plus hand-written stall, flush and
// reset sequences.
module tb_rv_decode_stage;

   logic        CLK;
   logic        RST_N;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] INSN;
   logic [31:0] pc_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_out;
   logic [4:0]  rsa, rsb, rd;
   logic [2:0]  func3;
   logic        sub_sra, alu_sel_a, alu_sel_b;
   logic [1:0]  rd_sel;
   logic [31:0] imm;
   logic [2:0]  sx_size;
   logic        pc_next_sel, branch, rd_we, mem_we, mem_re, illegal;

   rv_decode_stage #(
      .XLEN   (32),
      .SKID_EN(1'b1),
      .STRICT (1'b1)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .INSN       (INSN),
      .pc_in      (pc_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .pc_out     (pc_out),
      .rsa        (rsa),
      .rsb        (rsb),
      .rd         (rd),
      .func3      (func3),
      .sub_sra    (sub_sra),
      .alu_sel_a  (alu_sel_a),
      .alu_sel_b  (alu_sel_b),
      .rd_sel     (rd_sel),
      .imm        (imm),
      .sx_size    (sx_size),
      .pc_next_sel(pc_next_sel),
      .branch     (branch),
      .rd_we      (rd_we),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .illegal    (illegal)
   );

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic [4:0]  rsa;
      logic [4:0]  rsb;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        sub;
      logic        sa;
      logic        sb;
      logic [1:0]  rsel;
      logic [31:0] imm;
      logic [2:0]  sx;
      logic        pn;
      logic        br;
      logic        we;
      logic        mw;
      logic        mr;
      logic        ill;
   } vec_t;

   localparam int NumVec = 19;

   vec_t vecs [NumVec];
   int   n_vec = 0;
   int   n_bad = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] got_bits();
      return {rsa, rsb, rd, func3, sub_sra, alu_sel_a, alu_sel_b, rd_sel, imm, sx_size,
              pc_next_sel, branch, rd_we, mem_we, mem_re, illegal};
   endfunction

   function automatic logic [31:0] stream_insn(input int k);
      logic [31:0] n;
      n = 32'(k + 1);
      return (n << 20) | (n << 7) | 32'h13;  // ADDI x(k+1), x0, k+1
   endfunction

   initial begin
      vec_t v;
      int   sent, popped, cyc;
      bit   saw_low, any_valid;

      //                insn          pc        rsa    rsb    rd     f3    sub   sa    sb    rsel   imm            sx    pn    br    we    mw    mr    ill
      vecs[0]  = '{32'h002081B3, 32'h1000, 5'd1,  5'd2,  5'd3,  3'd0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'h407302B3, 32'h1004, 5'd6,  5'd7,  5'd5,  3'd0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'h4030D093, 32'h1008, 5'd1,  5'd0,  5'd1,  3'd5, 1'b1, 1'b0, 1'b1, 2'b10, 32'h00000003, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'hFE20AE23, 32'h100C, 5'd1,  5'd2,  5'd28, 3'd0, 1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFFFFFC, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{32'hFE208CE3, 32'h1010, 5'd1,  5'd2,  5'd25, 3'd0, 1'b1, 1'b0, 1'b0, 2'b10, 32'hFFFFFFF8, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{32'hFFFFFFFF, 32'h1014, 5'd31, 5'd31, 5'd31, 3'd7, 1'b0, 1'b0, 1'b0, 2'b10, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{32'h00000013, 32'h1018, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'h123452B7, 32'h101C, 5'd0,  5'd0,  5'd5,  3'd5, 1'b0, 1'b0, 1'b1, 2'b11, 32'h12345000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{32'hFFFFF097, 32'h1020, 5'd0,  5'd0,  5'd1,  3'd0, 1'b0, 1'b1, 1'b1, 2'b10, 32'hFFFFF000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{32'h008000EF, 32'h1024, 5'd0,  5'd0,  5'd1,  3'd0, 1'b0, 1'b1, 1'b1, 2'b01, 32'h00000008, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'h00008067, 32'h1028, 5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h00000000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'h00C12303, 32'h102C, 5'd2,  5'd0,  5'd6,  3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000000C, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{32'hFFF1C383, 32'h1030, 5'd3,  5'd0,  5'd7,  3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'hFFFFFFFF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{32'h0000B183, 32'h1034, 5'd1,  5'd0,  5'd3,  3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h00000000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{32'h022081B3, 32'h1038, 5'd1,  5'd2,  5'd3,  3'd0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{32'h402091B3, 32'h103C, 5'd1,  5'd2,  5'd3,  3'd1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[16] = '{32'h0020A063, 32'h1040, 5'd1,  5'd2,  5'd0,  3'd2, 1'b1, 1'b0, 1'b0, 2'b10, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[17] = '{32'hFFF12093, 32'h1044, 5'd2,  5'd0,  5'd1,  3'd2, 1'b1, 1'b0, 1'b1, 2'b10, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{32'h41F09093, 32'h1048, 5'd1,  5'd0,  5'd1,  3'd1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000001F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      RST_N     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      INSN      = '0;
      pc_in     = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_payload", {pc_out, got_bits()}, '0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      check("ready_after_reset", in_ready, 1'b1);

      // Back-to-back decode table, one instruction per cycle.
      out_ready = 1'b1;
      for (int i = 0; i < NumVec; i++) begin
         v        = vecs[i];
         in_valid = 1'b1;
         INSN     = v.insn;
         pc_in    = v.pc;
         @(posedge CLK);
         #1;
         check($sformatf("vec%0d_%h", i, v.insn), {out_valid, pc_out, got_bits()},
               {1'b1, v.pc, v[63:0]});
      end
      in_valid = 1'b0;
      @(posedge CLK);
      #1;
      check("drain_out_valid", out_valid, 1'b0);

      // Four-instruction stream with out_ready low for three cycles mid-stream.
      sent    = 0;
      popped  = 0;
      cyc     = 0;
      saw_low = 1'b0;
      while (popped < 4 && cyc < 40) begin
         out_ready = !(cyc >= 2 && cyc < 5);
         in_valid  = (sent < 4);
         INSN      = stream_insn(sent);
         pc_in     = 32'h2000 + 32'(sent * 4);
         @(negedge CLK);
         if (!in_ready && !saw_low) begin
            saw_low = 1'b1;
            check("held_at_stall", sent - popped, 2);
         end
         if (out_valid && out_ready) begin
            check($sformatf("stream_order%0d", popped), {pc_out, 27'd0, rd},
                  {32'h2000 + 32'(popped * 4), 27'd0, 5'(popped + 1)});
            popped++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge CLK);
         #1;
         cyc++;
      end
      check("stream_all_out", popped, 4);
      check("stream_ready_dropped", saw_low, 1'b1);

      // Fill output and skid, then flush with in_valid high.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      INSN      = stream_insn(0);
      @(posedge CLK);
      #1;
      INSN = stream_insn(1);
      @(posedge CLK);
      #1;
      check("skid_full_in_ready", in_ready, 1'b0);
      INSN  = stream_insn(2);
      flush = 1'b1;
      @(posedge CLK);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_clears_out", out_valid, 1'b0);
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      check("flush_no_emit", {out_valid, in_ready}, 2'b01);

      // Flush wins over an input that could otherwise be accepted.
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge CLK);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_drops_input", out_valid, 1'b0);

      // Asynchronous reset while stalled discards both buffered instructions.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      INSN      = stream_insn(0);
      repeat (2) @(posedge CLK);
      #1;
      in_valid = 1'b0;
      check("stall_loaded", {out_valid, in_ready}, 2'b10);
      RST_N = 1'b0;
      #1;
      check("async_reset_clears", out_valid, 1'b0);
      @(negedge CLK);
      RST_N     = 1'b1;
      out_ready = 1'b1;
      any_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge CLK);
         #1;
         any_valid |= out_valid;
      end
      check("reset_no_replay", any_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
